vga_syncgen: RTL and testbench

VGA_SYNCGEN -- requirements
Module: vga_syncgen

---
 rtl/vga_timing_pkg.sv | 20 ++
 rtl/sig_delay.sv | 37 +++
 rtl/vga_syncgen.sv | 112 +++++++++++
 tb/tb_vga_syncgen.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and the shared 10-bit counter type.
// Used by the sync generator as parameter defaults and for its range decode.
package vga_timing_pkg;

  typedef logic [9:0] cnt_t;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;

  function automatic logic in_range(input cnt_t val, input cnt_t lo, input cnt_t hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/sig_delay.sv
// Enable-gated shift register: DEPTH cycles of latency, stalls while en is low.
// All stages load RST_VAL on reset so nothing spurious appears downstream.
module sig_delay #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else if (en) begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_syncgen.sv
// VGA timing generator: H/V counters, sync/DE decode and a FRAME_START pulse.
// Counters registered; HS/VS/DE lag them by 1+DLY cycles; EN low freezes everything.
module vga_syncgen
  import vga_timing_pkg::*;
#(
  parameter int HVISIBLE = H_VISIBLE,
  parameter int HFP      = H_FP,
  parameter int HSYNC    = H_SYNC,
  parameter int HBP      = H_BP,
  parameter int VVISIBLE = V_VISIBLE,
  parameter int VFP      = V_FP,
  parameter int VSYNC    = V_SYNC,
  parameter int VBP      = V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int DLY      = 0
) (
  input  logic       PCK,
  input  logic       RST,
  input  logic       EN,
  output logic [9:0] HCNT,
  output logic [9:0] VCNT,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_DE,
  output logic       FRAME_START
);

  localparam int   HTOTAL   = HVISIBLE + HFP + HSYNC + HBP;
  localparam int   VTOTAL   = VVISIBLE + VFP + VSYNC + VBP;
  localparam cnt_t H_LAST   = cnt_t'(HTOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(VTOTAL - 1);
  localparam cnt_t H_ACT    = cnt_t'(HVISIBLE);
  localparam cnt_t V_ACT    = cnt_t'(VVISIBLE);
  localparam cnt_t HS_FIRST = cnt_t'(HVISIBLE + HFP);
  localparam cnt_t HS_LAST  = cnt_t'(HVISIBLE + HFP + HSYNC - 1);
  localparam cnt_t VS_FIRST = cnt_t'(VVISIBLE + VFP);
  localparam cnt_t VS_LAST  = cnt_t'(VVISIBLE + VFP + VSYNC - 1);
  localparam bit   INACT    = ~SYNC_POL;
  localparam logic [2:0] SYNC_IDLE = {INACT, INACT, 1'b0};

  if (HTOTAL > 1024 || VTOTAL > 1024) begin : g_bad_total
    $error("vga_syncgen: timing totals exceed the 10-bit counter range");
  end
  if (DLY < 0 || DLY > 7) begin : g_bad_dly
    $error("vga_syncgen: DLY must be within 0..7");
  end

  cnt_t       hcnt_q, hcnt_d;
  cnt_t       vcnt_q, vcnt_d;
  logic [2:0] sync_q, sync_d;
  logic [2:0] sync_out;
  logic       hs_raw, vs_raw, de_raw;

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (EN) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end
  end

  // Decode from the current count; the register below adds the one cycle of lag.
  always_comb begin
    hs_raw = in_range(hcnt_q, HS_FIRST, HS_LAST);
    vs_raw = in_range(vcnt_q, VS_FIRST, VS_LAST);
    de_raw = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    sync_d = sync_q;
    if (EN) begin
      sync_d = {hs_raw ? SYNC_POL : INACT, vs_raw ? SYNC_POL : INACT, de_raw};
    end
  end

  always_ff @(posedge PCK or posedge RST) begin
    if (RST) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      sync_q <= SYNC_IDLE;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      sync_q <= sync_d;
    end
  end

  if (DLY > 0) begin : g_dly
    sig_delay #(
      .WIDTH  (3),
      .DEPTH  (DLY),
      .RST_VAL(SYNC_IDLE)
    ) u_sig_delay (
      .clk (PCK),
      .rst (RST),
      .en  (EN),
      .din (sync_q),
      .dout(sync_out)
    );
  end else begin : g_nodly
    assign sync_out = sync_q;
  end

  assign {VGA_HS, VGA_VS, VGA_DE} = sync_out;
  assign HCNT        = hcnt_q;
  assign VCNT        = vcnt_q;
  // Taken straight off the counters so it stays aligned to HCNT/VCNT, not to the delayed syncs.
  assign FRAME_START = EN && !RST && (hcnt_q == '0) && (vcnt_q == '0);

endmodule

// File: tb/tb_vga_syncgen.sv
// Bench for vga_syncgen: default timing (DLY 0 and 3) plus a tiny active-high timing (DLY 1)
// used for whole-frame statistics, EN freeze and asynchronous reset corners.
module tb_vga_syncgen;

  logic pck = 1'b0;
  logic rst;
  logic en;

  logic [9:0] hcnt0, vcnt0, hcnt3, vcnt3, hcnts, vcnts;
  logic       hs0, vs0, de0, fs0;
  logic       hs3, vs3, de3, fs3;
  logic       hss, vss, des, fss;

  int n_checks = 0;
  int n_errors = 0;

  always #5 pck = ~pck;

  vga_syncgen u_dut0 (
    .PCK(pck), .RST(rst), .EN(en), .HCNT(hcnt0), .VCNT(vcnt0),
    .VGA_HS(hs0), .VGA_VS(vs0), .VGA_DE(de0), .FRAME_START(fs0)
  );

  vga_syncgen #(.DLY(3)) u_dut3 (
    .PCK(pck), .RST(rst), .EN(en), .HCNT(hcnt3), .VCNT(vcnt3),
    .VGA_HS(hs3), .VGA_VS(vs3), .VGA_DE(de3), .FRAME_START(fs3)
  );

  vga_syncgen #(
    .HVISIBLE(16), .HFP(2), .HSYNC(3), .HBP(3),
    .VVISIBLE(6), .VFP(1), .VSYNC(2), .VBP(1),
    .SYNC_POL(1'b1), .DLY(1)
  ) u_dsm (
    .PCK(pck), .RST(rst), .EN(en), .HCNT(hcnts), .VCNT(vcnts),
    .VGA_HS(hss), .VGA_VS(vss), .VGA_DE(des), .FRAME_START(fss)
  );

  localparam logic [2:0] IDLE_D = 3'b110;
  localparam logic [2:0] IDLE_S = 3'b000;
  localparam int SM_HT = 24;
  localparam int SM_VT = 10;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] ref_def(input int h, input int v);
    logic hs_a, vs_a, de_a;
    hs_a = (h >= 656) && (h <= 751);
    vs_a = (v >= 490) && (v <= 491);
    de_a = (h < 640) && (v < 480);
    return {~hs_a, ~vs_a, de_a};
  endfunction

  function automatic logic [2:0] ref_sm(input int h, input int v);
    logic hs_a, vs_a, de_a;
    hs_a = (h >= 18) && (h <= 20);
    vs_a = (v >= 7) && (v <= 8);
    de_a = (h < 16) && (v < 6);
    return {hs_a, vs_a, de_a};
  endfunction

  // Scoreboard model: each enabled edge pushes the decode of the pre-edge position and retires the oldest.
  int mh, mv, sh, sv;
  logic [2:0] q0[$];
  logic [2:0] q3[$];
  logic [2:0] qs[$];

  initial begin
    mh = 0; mv = 0; sh = 0; sv = 0;
    q0 = '{IDLE_D};
    q3 = '{IDLE_D, IDLE_D, IDLE_D, IDLE_D};
    qs = '{IDLE_S, IDLE_S};
    forever begin
      @(posedge pck or posedge rst);
      if (rst) begin
        mh = 0; mv = 0; sh = 0; sv = 0;
        q0 = '{IDLE_D};
        q3 = '{IDLE_D, IDLE_D, IDLE_D, IDLE_D};
        qs = '{IDLE_S, IDLE_S};
      end else if (en) begin
        q0.push_back(ref_def(mh, mv)); void'(q0.pop_front());
        q3.push_back(ref_def(mh, mv)); void'(q3.pop_front());
        qs.push_back(ref_sm(sh, sv));  void'(qs.pop_front());
        if (mh == 799) begin mh = 0; mv = (mv == 524) ? 0 : mv + 1; end
        else mh = mh + 1;
        if (sh == SM_HT - 1) begin sh = 0; sv = (sv == SM_VT - 1) ? 0 : sv + 1; end
        else sh = sh + 1;
      end
    end
  end

  // Per-cycle scoreboard compare plus run-length and frame statistics.
  int  de_run = 0, hs_run = 0;
  bit  de_done = 0, hs_done = 0;
  int  cyc_since = 0, dis_cnt = 0, de_cnt = 0, vs_cnt = 0;
  bit  fs_valid = 0;

  initial forever begin
    @(negedge pck);
    if (rst) begin
      fs_valid = 0;
    end else begin
      check("sb_dut0", {hcnt0, vcnt0, hs0, vs0, de0, fs0},
            {10'(mh), 10'(mv), q0[0], (mh == 0) && (mv == 0) && en});
      check("sb_dut3", {hcnt3, vcnt3, hs3, vs3, de3, fs3},
            {10'(mh), 10'(mv), q3[0], (mh == 0) && (mv == 0) && en});
      check("sb_dsm", {hcnts, vcnts, hss, vss, des, fss},
            {10'(sh), 10'(sv), qs[0], (sh == 0) && (sv == 0) && en});

      if (de0) de_run++;
      else if (de_run > 0 && !de_done) begin check("de0_run_len", de_run, 640); de_done = 1; end
      if (!hs0) hs_run++;
      else if (hs_run > 0 && !hs_done) begin check("hs0_low_len", hs_run, 96); hs_done = 1; end

      cyc_since++;
      if (!en) dis_cnt++;
      else begin
        if (des) de_cnt++;
        if (vss) vs_cnt++;
      end
      if (fss) begin
        if (fs_valid) begin
          check("sm_frame_period", cyc_since, SM_HT * SM_VT + dis_cnt);
          check("sm_frame_de", de_cnt, 16 * 6);
          check("sm_frame_vs", vs_cnt, 2 * SM_HT);
        end
        fs_valid = 1; cyc_since = 0; dis_cnt = 0; de_cnt = 0; vs_cnt = 0;
      end
    end
  end

  typedef struct {
    int   h;
    int   v;
    logic hs0, vs0, de0, hs3, de3;
  } vec_t;

  function automatic vec_t mk(input int h, input int v, input logic a, input logic b,
                              input logic c, input logic d, input logic e);
    vec_t r;
    r.h = h; r.v = v; r.hs0 = a; r.vs0 = b; r.de0 = c; r.hs3 = d; r.de3 = e;
    return r;
  endfunction

  task automatic wait_def(input int h, input int v, output bit ok);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge pck);
      if (hcnt0 == 10'(h) && vcnt0 == 10'(v)) begin ok = 1; break; end
    end
  endtask

  task automatic wait_sm(input int h, input int v, output bit ok);
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge pck);
      if (hcnts == 10'(h) && vcnts == 10'(v)) begin ok = 1; break; end
    end
  endtask

  vec_t tbl[$];
  bit   ok;

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    tbl.push_back(mk(3,   0, 1, 1, 1, 1, 0));
    tbl.push_back(mk(4,   0, 1, 1, 1, 1, 1));
    tbl.push_back(mk(640, 0, 1, 1, 1, 1, 1));
    tbl.push_back(mk(641, 0, 1, 1, 0, 1, 1));
    tbl.push_back(mk(643, 0, 1, 1, 0, 1, 1));
    tbl.push_back(mk(644, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk(656, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk(657, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(660, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(752, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(753, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(756, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk(799, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0,   1, 1, 1, 0, 1, 0));
    tbl.push_back(mk(1,   1, 1, 1, 1, 1, 0));
    tbl.push_back(mk(4,   1, 1, 1, 1, 1, 1));

    // Reset held 20 cycles; EN raised half way to prove FRAME_START stays low under reset.
    for (int i = 0; i < 20; i++) begin
      @(negedge pck);
      check("rst_dut0", {hcnt0, vcnt0, hs0, vs0, de0, fs0}, {20'd0, 3'b110, 1'b0});
      check("rst_dut3", {hs3, vs3, de3, fs3}, 4'b1100);
      check("rst_dsm", {hcnts, vcnts, hss, vss, des, fss}, 24'd0);
      #1;
      if (i == 9) en = 1'b1;
    end
    rst = 1'b0;

    @(negedge pck);
    check("first_edge", {hcnt0, vcnt0}, {10'd1, 10'd0});

    foreach (tbl[k]) begin
      wait_def(tbl[k].h, tbl[k].v, ok);
      check("tbl_reach", ok, 1'b1);
      if (ok) begin
        check("tbl_dut0", {hs0, vs0, de0}, {tbl[k].hs0, tbl[k].vs0, tbl[k].de0});
        check("tbl_dut3", {hs3, de3}, {tbl[k].hs3, tbl[k].de3});
      end
    end

    // EN dropped for 50 cycles at HCNT=300.
    wait_def(300, 1, ok);
    check("freeze_reach", ok, 1'b1);
    #1 en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge pck);
      check("freeze_hcnt", {hcnt0, vcnt0}, {10'd300, 10'd1});
      check("freeze_fs", {fs0, fs3, fss}, 3'b000);
    end
    #1 en = 1'b1;
    @(negedge pck);
    check("resume_hcnt", {hcnt0, vcnt0}, {10'd301, 10'd1});

    // Asynchronous reset while the small timing has HS and VS both active.
    wait_sm(20, 8, ok);
    check("sm_sync_reach", ok, 1'b1);
    check("sm_sync_active", {hss, vss}, 2'b11);
    #1 rst = 1'b1;
    #1;
    check("async_rst_dsm", {hcnts, vcnts, hss, vss, des, fss}, 24'd0);
    check("async_rst_dut0", {hcnt0, hs0, vs0, de0, fs0}, {10'd0, 4'b1100});
    check("async_rst_dut3", {hs3, vs3, de3}, 3'b110);
    repeat (3) @(negedge pck);
    #1 rst = 1'b0;
    #1;
    check("restart_fs", {fss, fs0, hcnts, vcnts}, {2'b11, 20'd0});
    @(negedge pck);
    check("restart_edge", {hcnts, vcnts, hcnt0}, {10'd1, 10'd0, 10'd1});

    // Let a few more small frames run through the frame statistics.
    repeat (600) @(negedge pck);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
